// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_hazard_ctrl
// Description : ID-stage branch/jump hazard controller: operand-dependency
//               stalls, same-cycle redirect/flush and optional statistics
//               (enabled by defining BRANCH_HAZARD_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_Branch,
  input  logic             ID_Jump,
  input  logic             ID_JumpReg,
  input  logic             ID_UsesRt,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteAddr,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_WriteAddr,
  input  logic             BranchHazard,
  input  logic             ExtStall,
  output logic             PC_Stall,
  output logic             IFID_Stall,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             PC_Redirect,
  output logic [CNT_W-1:0] TakenCount,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STALL1  = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;

  logic needs_ops;
  logic dep_ex;
  logic dep_mem;
  logic load_use;
  logic alu_dep;
  logic resolve_now;
  logic stall;
  logic redirect;

  // Only conditional branches compare Rt; jr/jalr read Rs alone.
  assign needs_ops = ID_Branch | (ID_Jump & ID_JumpReg);

  assign dep_ex  = EX_RegWrite & (EX_WriteAddr != 5'd0) &
                   ((EX_WriteAddr == ID_Rs) |
                    (ID_Branch & ID_UsesRt & (EX_WriteAddr == ID_Rt)));

  assign dep_mem = MEM_RegWrite & MEM_MemRead & (MEM_WriteAddr != 5'd0) &
                   ((MEM_WriteAddr == ID_Rs) |
                    (ID_Branch & ID_UsesRt & (MEM_WriteAddr == ID_Rt)));

  assign load_use    = needs_ops & dep_ex & EX_MemRead;
  assign alu_dep     = needs_ops & ((dep_ex & ~EX_MemRead) | dep_mem);
  assign resolve_now = (ID_Branch & BranchHazard) | ID_Jump;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ExtStall) begin
      case (state_q)
        ST_IDLE: begin
          if (load_use) begin
            state_d = ST_STALL1;
          end else if (alu_dep) begin
            state_d = ST_RESOLVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_STALL1:  state_d = ST_RESOLVE;
        ST_RESOLVE: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall    = 1'b0;
    redirect = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_use | alu_dep) begin
          stall = 1'b1;
        end else begin
          redirect = resolve_now;
        end
      end
      ST_STALL1:  stall    = 1'b1;
      ST_RESOLVE: redirect = resolve_now;
      default: begin
        stall    = 1'b0;
        redirect = 1'b0;
      end
    endcase
    // A global freeze or reset overrides every hazard decision.
    if (reset || ExtStall) begin
      stall    = 1'b0;
      redirect = 1'b0;
    end
  end

  assign PC_Stall    = stall;
  assign IFID_Stall  = stall;
  assign IDEX_Bubble = stall;
  assign IFID_Flush  = redirect;
  assign PC_Redirect = redirect;

`ifdef BRANCH_HAZARD_STATS_EN
  logic [CNT_W-1:0] taken_q;
  logic [CNT_W-1:0] taken_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  always_comb begin
    taken_d     = taken_q + {{(CNT_W-1){1'b0}}, redirect};
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      taken_q     <= taken_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign TakenCount = taken_q;
  assign StallCount = stall_cnt_q;
`else
  assign TakenCount = '0;
  assign StallCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
`default_nettype none
// Self-checking bench for branch_hazard_ctrl: decode table from IDLE plus
// multi-cycle sequences for stalls, freeze, mid-stall reset and counter wrap.
module tb_branch_hazard_ctrl;

  localparam int CW = 4;
`ifdef BRANCH_HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] ST = 5'b11100;
  localparam logic [4:0] FL = 5'b00011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic br = 0, jmp = 0, jr = 0, ut = 0, exw = 0, exr = 0, mw = 0, mr = 0, bh = 0, ext = 0;
  logic [4:0] rs = 0, rt = 0, exa = 0, ma = 0;
  logic pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect;
  logic [CW-1:0] taken_cnt, stall_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ID_Branch(br), .ID_Jump(jmp), .ID_JumpReg(jr), .ID_UsesRt(ut),
    .ID_Rs(rs), .ID_Rt(rt),
    .EX_RegWrite(exw), .EX_MemRead(exr), .EX_WriteAddr(exa),
    .MEM_RegWrite(mw), .MEM_MemRead(mr), .MEM_WriteAddr(ma),
    .BranchHazard(bh), .ExtStall(ext),
    .PC_Stall(pc_stall), .IFID_Stall(ifid_stall), .IDEX_Bubble(idex_bubble),
    .IFID_Flush(ifid_flush), .PC_Redirect(pc_redirect),
    .TakenCount(taken_cnt), .StallCount(stall_cnt)
  );

  typedef struct {
    logic br, jmp, jr, ut;
    logic [4:0] rs, rt;
    logic exw, exr;
    logic [4:0] exa;
    logic mw, mr;
    logic [4:0] ma;
    logic bh, ext;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic b, logic j, logic r, logic u, logic [4:0] s, logic [4:0] t,
                              logic ew, logic er, logic [4:0] ea, logic w, logic m, logic [4:0] a,
                              logic h, logic x, logic [4:0] e);
    vec_t v;
    v.br = b; v.jmp = j; v.jr = r; v.ut = u; v.rs = s; v.rt = t;
    v.exw = ew; v.exr = er; v.exa = ea; v.mw = w; v.mr = m; v.ma = a;
    v.bh = h; v.ext = x; v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    br = v.br; jmp = v.jmp; jr = v.jr; ut = v.ut; rs = v.rs; rt = v.rt;
    exw = v.exw; exr = v.exr; exa = v.exa; mw = v.mw; mr = v.mr; ma = v.ma;
    bh = v.bh; ext = v.ext;
  endtask

  task automatic nop();
    drive(mk(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0, NO));
  endtask

  task automatic check_ctl(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: ctl got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CW-1:0] et, input logic [CW-1:0] es);
    total++;
    if (taken_cnt !== et || stall_cnt !== es) begin
      bad++;
      $display("FAIL %s: taken/stall got %0d/%0d want %0d/%0d", name, taken_cnt, stall_cnt, et, es);
    end
  endtask

  function automatic logic [CW-1:0] ec(input int n);
    return STATS ? CW'(n) : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Common operand patterns for the sequences.
  vec_t lw_beq, add_bne, beq_tk;

  initial begin
    vecs[0]  = mk(1,0,0,1, 1,2, 0,0,0, 0,0,0, 1,0, FL);
    vecs[1]  = mk(1,0,0,1, 1,2, 0,0,0, 0,0,0, 0,0, NO);
    vecs[2]  = mk(1,0,0,1, 3,4, 1,1,3, 0,0,0, 1,0, ST);
    vecs[3]  = mk(1,0,0,1, 0,5, 1,0,5, 0,0,0, 1,0, ST);
    vecs[4]  = mk(1,0,0,1, 0,0, 1,0,0, 0,0,0, 1,0, FL);
    vecs[5]  = mk(1,0,0,0, 1,5, 1,0,5, 0,0,0, 1,0, FL);
    vecs[6]  = mk(1,0,0,1, 7,8, 0,0,0, 1,1,7, 0,0, ST);
    vecs[7]  = mk(1,0,0,1, 8,7, 0,0,0, 1,1,7, 0,0, ST);
    vecs[8]  = mk(1,0,0,1, 7,8, 0,0,0, 1,0,7, 1,0, FL);
    vecs[9]  = mk(1,0,0,1, 0,8, 0,0,0, 1,1,0, 1,0, FL);
    vecs[10] = mk(0,1,0,0, 3,0, 1,1,3, 0,0,0, 0,0, FL);
    vecs[11] = mk(0,1,1,0, 3,0, 1,0,3, 0,0,0, 0,0, ST);
    vecs[12] = mk(0,1,1,1, 1,5, 1,1,5, 0,0,0, 0,0, FL);
    vecs[13] = mk(0,0,0,0, 3,4, 1,1,3, 0,0,0, 1,0, NO);
    vecs[14] = mk(1,0,0,1, 3,4, 1,1,3, 0,0,0, 1,1, NO);
    vecs[15] = mk(1,0,0,1, 1,2, 0,0,0, 0,0,0, 1,1, NO);
    vecs[16] = mk(1,0,0,1, 3,4, 0,1,3, 0,0,0, 1,0, FL);
    vecs[17] = mk(1,0,0,1, 7,8, 0,0,0, 0,1,7, 1,0, FL);

    lw_beq  = vecs[2];
    add_bne = vecs[3];
    beq_tk  = vecs[0];

    // Reset state; outputs held low even with a stalling pattern applied.
    drive(lw_beq);
    #2;
    check_ctl("during_reset", NO);
    nop();
    do_reset();
    check_ctl("after_reset", NO);
    check_cnt("after_reset_cnt", '0, '0);

    // Decode table, each entry evaluated fresh from IDLE.
    for (int i = 0; i < 18; i++) begin
      nop();
      do_reset();
      drive(vecs[i]);
      #1;
      check_ctl($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Load-use: two stall cycles, then redirect in RESOLVE.
    nop(); do_reset();
    drive(lw_beq); #1;
    check_ctl("lu_idle", ST);
    tick();
    exw = 0; exr = 0; exa = 0; mw = 1; mr = 1; ma = 3; #1;
    check_ctl("lu_stall1", ST);
    tick();
    mw = 0; mr = 0; ma = 0; #1;
    check_ctl("lu_resolve", FL);
    tick();
    nop(); #1;
    check_ctl("lu_back_idle", NO);
    check_cnt("lu_cnt", ec(1), ec(2));

    // ALU dependency: one stall cycle, then resolve.
    nop(); do_reset();
    drive(add_bne); bh = 0; #1;
    check_ctl("alu_idle", ST);
    tick();
    exw = 0; exa = 0; bh = 1; #1;
    check_ctl("alu_resolve", FL);
    tick();
    nop(); #1;
    check_ctl("alu_back_idle", NO);
    check_cnt("alu_cnt", ec(1), ec(1));

    // Freeze while in STALL1 for three cycles.
    nop(); do_reset();
    drive(lw_beq); #1;
    check_ctl("fz_idle", ST);
    tick();
    ext = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_ctl($sformatf("fz_hold%0d", k), NO);
      tick();
    end
    check_cnt("fz_cnt_hold", ec(0), ec(1));
    ext = 0; exw = 0; exr = 0; #1;
    check_ctl("fz_stall1", ST);
    tick();
    check_ctl("fz_resolve", FL);
    tick();
    nop(); #1;
    check_ctl("fz_idle_end", NO);
    check_cnt("fz_cnt", ec(1), ec(2));

    // Reset pulse mid-stall abandons the sequence.
    nop(); do_reset();
    drive(lw_beq); #1;
    tick();
    check_ctl("rst_stall1", ST);
    check_cnt("rst_cnt_pre", ec(0), ec(1));
    #2;
    reset = 1'b1;
    #1;
    check_ctl("rst_async_out", NO);
    check_cnt("rst_async_cnt", '0, '0);
    tick();
    reset = 1'b0;
    drive(beq_tk); #1;
    check_ctl("rst_fresh_idle", FL);
    tick();
    nop(); #1;
    check_cnt("rst_fresh_cnt", ec(1), ec(0));

    // Seventeen taken branches wrap a 4-bit TakenCount to 1.
    nop(); do_reset();
    drive(beq_tk);
    for (int k = 0; k < 17; k++) tick();
    nop(); #1;
    check_cnt("wrap_cnt", ec(1), ec(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of statistics counters.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: ID_Branch  in  1  conditional branch in ID.
REQ-005 SHALL have ports: ID_Jump  in  1  j/jal/jr in ID.
REQ-006 SHALL have ports: ID_JumpReg  in  1  jump reads Rs (jr/jalr).
REQ-007 SHALL have ports: ID_UsesRt  in  1  branch compares Rt (beq/bne).
REQ-008 SHALL have ports: ID_Rs, ID_Rt  in  5  ID source registers.
REQ-009 SHALL have ports: EX_RegWrite, EX_MemRead  in  1  EX-stage write / load flags.
REQ-010 SHALL have ports: EX_WriteAddr  in  5  EX destination register.
REQ-011 SHALL have ports: MEM_RegWrite, MEM_MemRead  in  1  MEM-stage write / load flags.
REQ-012 SHALL have ports: MEM_WriteAddr  in  5  MEM destination register.
REQ-013 SHALL have ports: BranchHazard  in  1  branch-taken result from ID comparator.
REQ-014 SHALL have ports: ExtStall  in  1  global freeze (memory wait).
REQ-015 SHALL have ports: PC_Stall, IFID_Stall  out  1  hold PC / IF-ID register.
REQ-016 SHALL have ports: IDEX_Bubble  out  1  insert NOP into ID/EX.
REQ-017 SHALL have ports: IFID_Flush, PC_Redirect  out  1  squash fetched instr / select target.
REQ-018 SHALL have ports: TakenCount, StallCount  out  CNT_W  statistics.

Function
REQ-019 SHALL define depEX = EX_RegWrite & EX_WriteAddr!=0 & (EX_WriteAddr==ID_Rs | (ID_UsesRt & EX_WriteAddr==ID_Rt)); depMEM likewise with MEM_*, qualified by MEM_MemRead.
REQ-020 SHALL treat "needs operands" = ID_Branch | (ID_Jump & ID_JumpReg); Rt term applies only to ID_Branch.
REQ-021 SHALL implement FSM states IDLE, STALL1, RESOLVE; reset state IDLE.
REQ-022 IDLE, needs operands & depEX & EX_MemRead: stall outputs =1, next STALL1 (2 stall cycles total).
REQ-023 IDLE, needs operands & ((depEX & ~EX_MemRead) | depMEM): stall outputs =1, next RESOLVE (1 stall cycle).
REQ-024 STALL1: stall outputs =1 unconditionally (no re-evaluation), next RESOLVE.
REQ-025 RESOLVE, or IDLE with no dependency: ID_Branch & BranchHazard, or ID_Jump -> IFID_Flush=PC_Redirect=1 same cycle; next IDLE.
REQ-026 "Stall outputs" = PC_Stall, IFID_Stall, IDEX_Bubble together; never asserted in the same cycle as IFID_Flush.
REQ-027 Outputs SHALL be combinational from state and inputs; resolution latency 0 cycles after last stall.
REQ-028 ExtStall=1: FSM holds state, all five control outputs =0, counters hold; takes priority over every other event.
REQ-029 Non-branch, non-jump in ID in IDLE: all control outputs 0, stay IDLE.

Reset
REQ-030 reset=1 SHALL asynchronously force state IDLE and TakenCount=StallCount=0.
REQ-031 While reset=1 all control outputs SHALL be 0 regardless of inputs.
REQ-032 Reset asserted mid-stall SHALL abandon the sequence; first cycle after release evaluates in IDLE.

Configuration
REQ-033 Macro BRANCH_HAZARD_STATS_EN defined: TakenCount +1 on each cycle with PC_Redirect=1, StallCount +1 on each cycle with PC_Stall=1; both wrap modulo 2^CNT_W.
REQ-034 Macro undefined: counter registers absent, TakenCount/StallCount ports present and tied to 0.

Verification
REQ-035 beq $1,$2 taken, no deps, BranchHazard=1 -> same cycle IFID_Flush=PC_Redirect=1, no stall.
REQ-036 lw $3 in EX (EX_MemRead=1, EX_WriteAddr=3), ID beq $3,$4 -> 2 stall cycles (IDLE->STALL1->RESOLVE), then redirect if BranchHazard=1; StallCount=2.
REQ-037 add $5 in EX, ID bne $0,$5 (ID_UsesRt=1) -> 1 stall cycle then resolve; EX_WriteAddr=0 case -> no stall.
REQ-038 STALL1 with ExtStall=1 for 3 cycles -> outputs 0, state held, then 1 stall cycle and RESOLVE follow.
REQ-039 reset pulse during STALL1 -> outputs 0 immediately, counters 0, next branch evaluated fresh from IDLE.
REQ-040 STATS_EN with CNT_W=4, 17 taken branches -> TakenCount=1 (wrap); without macro -> counts stay 0.
